// File: rtl/mode_scheduler.sv
// rtl/mode_scheduler.sv - staged TX/RX mode change scheduler with startup hold
module mode_scheduler #(
  parameter int RST_HOLD = 100,
  parameter int M_MAX    = 5,
  parameter int SS_MAX   = 9,
  parameter int BW_MAX   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_m,
  input  logic [3:0] cfg_ss,
  input  logic [2:0] cfg_bw,
  input  logic       sof_tx,
  input  logic       sof_rx,
  output logic [2:0] tx_m,
  output logic [3:0] tx_ss,
  output logic [2:0] tx_bw,
  output logic [2:0] rx_m,
  output logic [3:0] rx_ss,
  output logic [2:0] rx_bw,
  output logic       tx_applied,
  output logic       rx_applied,
  output logic       cfg_err,
  output logic       busy,
  output logic       run
);

  // Counter must hold RST_HOLD itself so it can saturate there
  localparam int CW = (RST_HOLD < 1) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [CW-1:0] HOLD_L   = CW'(RST_HOLD);
  localparam logic [2:0]    M_MAX_L  = 3'(M_MAX);
  localparam logic [3:0]    SS_MAX_L = 4'(SS_MAX);
  localparam logic [2:0]    BW_MAX_L = 3'(BW_MAX);

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    WAIT_TX = 2'd2,
    WAIT_RX = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          hold_done;
  logic          accept;
  logic          cfg_legal;
  logic          tx_load;
  logic          rx_load;
  logic [2:0]    pend_m;
  logic [3:0]    pend_ss;
  logic [2:0]    pend_bw;

  // A zero hold leaves INIT on the first edge after reset release
  assign hold_done = (RST_HOLD == 0) || (cnt >= HOLD_L - CW'(1));
  assign accept    = cfg_valid && cfg_ready;
  assign cfg_legal = (cfg_m != 3'd0) && (cfg_m <= M_MAX_L) &&
                     (cfg_ss != 4'd0) && (cfg_ss <= SS_MAX_L) &&
                     (cfg_bw <= BW_MAX_L);
  // TX always leads; RX may load with TX only when both frames start together
  assign tx_load   = (state == WAIT_TX) && sof_tx;
  assign rx_load   = ((state == WAIT_TX) && sof_tx && sof_rx) ||
                     ((state == WAIT_RX) && sof_rx);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (hold_done) state_nxt = IDLE;
      IDLE:    if (accept && cfg_legal) state_nxt = WAIT_TX;
      WAIT_TX: begin
        if (sof_tx && sof_rx) state_nxt = IDLE;
        else if (sof_tx)      state_nxt = WAIT_RX;
      end
      WAIT_RX: if (sof_rx) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    run       = 1'b1;
    case (state)
      INIT:    run       = 1'b0;
      IDLE:    cfg_ready = 1'b1;
      WAIT_TX: busy      = 1'b1;
      WAIT_RX: busy      = 1'b1;
      default: run       = 1'b0;
    endcase
  end

  // Startup hold counter, saturating at RST_HOLD
  always_ff @(posedge clk) begin
    if (rst)                                cnt <= '0;
    else if (state == INIT && cnt != HOLD_L) cnt <= cnt + CW'(1);
  end

  // Pending/active configuration registers and one-cycle event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_m     <= 3'd0;
      pend_ss    <= 4'd0;
      pend_bw    <= 3'd0;
      tx_m       <= 3'd1;
      tx_ss      <= 4'd1;
      tx_bw      <= 3'd0;
      rx_m       <= 3'd1;
      rx_ss      <= 4'd1;
      rx_bw      <= 3'd0;
      tx_applied <= 1'b0;
      rx_applied <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      tx_applied <= tx_load;
      rx_applied <= rx_load;
      cfg_err    <= accept && !cfg_legal;
      if (accept && cfg_legal) begin
        pend_m  <= cfg_m;
        pend_ss <= cfg_ss;
        pend_bw <= cfg_bw;
      end
      if (tx_load) begin
        tx_m  <= pend_m;
        tx_ss <= pend_ss;
        tx_bw <= pend_bw;
      end
      if (rx_load) begin
        rx_m  <= pend_m;
        rx_ss <= pend_ss;
        rx_bw <= pend_bw;
      end
    end
  end

endmodule

// File: tb/tb_mode_scheduler.sv
// tb/tb_mode_scheduler.sv - scoreboard bench for mode_scheduler
module tb_mode_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_m;
  logic [3:0] cfg_ss;
  logic [2:0] cfg_bw;
  logic       sof_tx;
  logic       sof_rx;
  logic [2:0] tx_m, rx_m, tx_bw, rx_bw;
  logic [3:0] tx_ss, rx_ss;
  logic       tx_applied, rx_applied, cfg_err, busy, run;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] kind;  // {tx_applied, rx_applied, cfg_err}
    logic [9:0] tx;
    logic [9:0] rx;
  } ev_t;

  ev_t ev_q[$];

  localparam logic [9:0] DEF_CFG = {3'd1, 4'd1, 3'd0};

  mode_scheduler dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_m(cfg_m), .cfg_ss(cfg_ss), .cfg_bw(cfg_bw),
    .sof_tx(sof_tx), .sof_rx(sof_rx),
    .tx_m(tx_m), .tx_ss(tx_ss), .tx_bw(tx_bw),
    .rx_m(rx_m), .rx_ss(rx_ss), .rx_bw(rx_bw),
    .tx_applied(tx_applied), .rx_applied(rx_applied),
    .cfg_err(cfg_err), .busy(busy), .run(run)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] pack(input logic [2:0] m, input logic [3:0] ss, input logic [2:0] bw);
    return {m, ss, bw};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic [2:0] kind, input logic [9:0] tx, input logic [9:0] rx);
    ev_t e;
    e.kind = kind;
    e.tx   = tx;
    e.rx   = rx;
    ev_q.push_back(e);
  endtask

  // Every event pulse is matched against the oldest expected event
  always @(negedge clk) begin
    if (tx_applied || rx_applied || cfg_err) begin
      if (ev_q.size() == 0) begin
        chk("unexpected_event", 32'({tx_applied, rx_applied, cfg_err}), 32'd0);
      end else begin
        ev_t e;
        e = ev_q.pop_front();
        chk("event_kind", 32'({tx_applied, rx_applied, cfg_err}), 32'(e.kind));
        chk("event_tx", 32'(pack(tx_m, tx_ss, tx_bw)), 32'(e.tx));
        chk("event_rx", 32'(pack(rx_m, rx_ss, rx_bw)), 32'(e.rx));
      end
    end
  end

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    chk({tag, "_run_low"}, 32'(run), 32'd0);
    chk({tag, "_ready_low"}, 32'(cfg_ready), 32'd0);
    while (!run && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_hold_cycles"}, 32'(n), 32'd100);
    chk({tag, "_ready_high"}, 32'(cfg_ready), 32'd1);
  endtask

  task automatic send_cfg(input logic [2:0] m, input logic [3:0] ss, input logic [2:0] bw);
    int n;
    n = 0;
    while (!cfg_ready && n < 50) begin
      tick();
      n++;
    end
    chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_m     = m;
    cfg_ss    = ss;
    cfg_bw    = bw;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse(input logic t, input logic r);
    sof_tx = t;
    sof_rx = r;
    tick();
    sof_tx = 1'b0;
    sof_rx = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] cur_tx;
    logic [9:0] cur_rx;
    logic [9:0] bad_tab [5];
    bad_tab[0] = pack(3'd6, 4'd4, 3'd2);
    bad_tab[1] = pack(3'd3, 4'd0, 3'd2);
    bad_tab[2] = pack(3'd0, 4'd1, 3'd0);
    bad_tab[3] = pack(3'd3, 4'd10, 3'd0);
    bad_tab[4] = pack(3'd3, 4'd4, 3'd5);

    rst = 1'b1; cfg_valid = 1'b0; cfg_m = 3'd0; cfg_ss = 4'd0; cfg_bw = 3'd0;
    sof_tx = 1'b0; sof_rx = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx", 32'(pack(tx_m, tx_ss, tx_bw)), 32'(DEF_CFG));
    chk("rst_rx", 32'(pack(rx_m, rx_ss, rx_bw)), 32'(DEF_CFG));
    rst = 1'b0;
    wait_run("startup");

    // Normal change: TX first, RX later
    send_cfg(3'd3, 4'd4, 3'd2);
    chk("norm_busy", 32'(busy), 32'd1);
    chk("norm_ready", 32'(cfg_ready), 32'd0);
    repeat (10) tick();
    cur_tx = pack(3'd3, 4'd4, 3'd2);
    cur_rx = DEF_CFG;
    push_ev(3'b100, cur_tx, cur_rx);
    pulse(1'b1, 1'b0);
    chk("norm_rx_held", 32'(pack(rx_m, rx_ss, rx_bw)), 32'(DEF_CFG));
    chk("norm_busy_wrx", 32'(busy), 32'd1);
    repeat (3) tick();
    pulse(1'b1, 1'b0);
    chk("wrx_ignore_tx", 32'(busy), 32'd1);
    cur_rx = cur_tx;
    push_ev(3'b010, cur_tx, cur_rx);
    pulse(1'b0, 1'b1);
    chk("norm_idle_busy", 32'(busy), 32'd0);
    chk("norm_idle_ready", 32'(cfg_ready), 32'd1);
    tick();

    // Rejected requests
    for (int i = 0; i < 5; i++) begin
      push_ev(3'b001, cur_tx, cur_rx);
      send_cfg(bad_tab[i][9:7], bad_tab[i][6:3], bad_tab[i][2:0]);
      chk("rej_ready", 32'(cfg_ready), 32'd1);
      chk("rej_busy", 32'(busy), 32'd0);
      tick();
    end

    // Largest legal values, both frames together
    send_cfg(3'd5, 4'd9, 3'd4);
    chk("sim_busy", 32'(busy), 32'd1);
    tick();
    cur_tx = pack(3'd5, 4'd9, 3'd4);
    cur_rx = cur_tx;
    push_ev(3'b110, cur_tx, cur_rx);
    pulse(1'b1, 1'b1);
    chk("sim_busy_after", 32'(busy), 32'd0);
    tick();

    // RX before TX is ignored
    send_cfg(3'd2, 4'd1, 3'd0);
    pulse(1'b0, 1'b1);
    chk("ign_busy", 32'(busy), 32'd1);
    chk("ign_rx", 32'(pack(rx_m, rx_ss, rx_bw)), 32'(cur_rx));
    cur_tx = pack(3'd2, 4'd1, 3'd0);
    push_ev(3'b100, cur_tx, cur_rx);
    pulse(1'b1, 1'b0);
    cur_rx = cur_tx;
    push_ev(3'b010, cur_tx, cur_rx);
    pulse(1'b0, 1'b1);
    chk("ign_done", 32'(busy), 32'd0);
    tick();

    // Reset after TX load drops the pending RX change
    send_cfg(3'd4, 4'd7, 3'd3);
    push_ev(3'b100, pack(3'd4, 4'd7, 3'd3), cur_rx);
    pulse(1'b1, 1'b0);
    chk("mid_wrx", 32'(busy), 32'd1);
    rst = 1'b1;
    sof_rx = 1'b1;
    tick();
    chk("mid_tx_def", 32'(pack(tx_m, tx_ss, tx_bw)), 32'(DEF_CFG));
    chk("mid_rx_def", 32'(pack(rx_m, rx_ss, rx_bw)), 32'(DEF_CFG));
    chk("mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_run("restart");
    sof_rx = 1'b0;
    repeat (3) tick();
    chk("queue_empty", 32'(ev_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mode_scheduler.md
MODE_SCHEDULER -- requirements
Module: mode_scheduler

Interface
REQ-001 The block SHALL have the parameter RST_HOLD, default 100, giving the startup hold length in clk cycles after reset.
REQ-002 The block SHALL have the parameter M_MAX, default 5, giving the largest legal modulation index.
REQ-003 The block SHALL have the parameter SS_MAX, default 9, giving the largest legal spreading index.
REQ-004 The block SHALL have the parameter BW_MAX, default 4, giving the largest legal bandwidth index.
REQ-005 The block SHALL have the following ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- cfg_valid  in  1  host configuration request valid.
- cfg_ready  out  1  block accepts a request.
- cfg_m  in  3  requested modulation index.
- cfg_ss  in  4  requested spreading index.
- cfg_bw  in  3  requested bandwidth index.
- sof_tx  in  1  TX start-of-frame pulse.
- sof_rx  in  1  RX start-of-frame pulse.
- tx_m / tx_ss / tx_bw  out  3/4/3  active TX configuration.
- rx_m / rx_ss / rx_bw  out  3/4/3  active RX configuration.
- tx_applied  out  1  one-cycle pulse: pending config loaded into TX.
- rx_applied  out  1  one-cycle pulse: pending config loaded into RX.
- cfg_err  out  1  one-cycle pulse: rejected request.
- busy  out  1  change pending.
- run  out  1  datapath enable; low during startup hold.

Function
REQ-006 The block SHALL implement four states: INIT, IDLE, WAIT_TX and WAIT_RX.
REQ-007 INIT SHALL count RST_HOLD cycles from reset release, then enter IDLE; run SHALL rise on the IDLE entry cycle and stay high until reset.
REQ-008 cfg_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where cfg_valid and cfg_ready are both 1.
REQ-009 An accepted request with cfg_m=0 or cfg_m>M_MAX, cfg_ss=0 or cfg_ss>SS_MAX, or cfg_bw>BW_MAX SHALL cause a cfg_err pulse the next cycle, leave the state at IDLE, and leave all config outputs unchanged.
REQ-010 An accepted legal request SHALL be stored as pending and SHALL move the state to WAIT_TX on the next cycle.
REQ-011 In WAIT_TX, sof_tx SHALL load the pending values into tx_m/tx_ss/tx_bw on the next clock edge, with tx_applied high that same cycle, and SHALL move the state to WAIT_RX.
REQ-012 In WAIT_TX, sof_rx without sof_tx SHALL be ignored, and the rx outputs SHALL be unchanged.
REQ-013 In WAIT_TX, simultaneous sof_tx and sof_rx SHALL load both TX and RX, pulse tx_applied and rx_applied on the same cycle, and move the state to IDLE.
REQ-014 In WAIT_RX, sof_rx SHALL load the pending values into the rx outputs on the next edge, pulse rx_applied, and move the state to IDLE; sof_tx SHALL be ignored in WAIT_RX.
REQ-015 busy SHALL be 1 exactly in WAIT_TX and WAIT_RX.
REQ-016 sof_tx and sof_rx SHALL be ignored in INIT and IDLE.
REQ-017 The config outputs SHALL change only as specified in REQ-011, REQ-013 and REQ-014.
REQ-018 The INIT counter SHALL be wide enough for RST_HOLD and SHALL saturate without wrap-around.
REQ-019 With RST_HOLD=0, the block SHALL enter IDLE on the first cycle after reset release.

Reset
REQ-020 While rst=1, the block SHALL hold the following values: state INIT; counter 0; run=0; cfg_ready=0; busy=0; all pulse outputs 0; tx_m=rx_m=1; tx_ss=rx_ss=1; tx_bw=rx_bw=0; pending cleared.
REQ-021 Reset asserted in WAIT_TX or WAIT_RX SHALL discard the pending change; no applied pulse SHALL follow, and the outputs SHALL return to the REQ-020 defaults.

Verification
REQ-022 The bench SHALL cover startup: rst high for 3 cycles, then low -> run=0 and cfg_ready=0 for 100 cycles, then run=1 and cfg_ready=1.
REQ-023 The bench SHALL cover a normal change: request m=3, ss=4, bw=2, then sof_tx 10 cycles later -> tx=(3,4,2) plus tx_applied; rx stays (1,1,0) until sof_rx -> rx=(3,4,2) plus rx_applied, then IDLE.
REQ-024 The bench SHALL cover rejection: request m=6 (and separately ss=0) -> one cfg_err pulse, outputs unchanged, cfg_ready remains 1.
REQ-025 The bench SHALL cover simultaneous pulses: in WAIT_TX, sof_tx and sof_rx on the same cycle -> both applied pulses on one cycle, busy=0 the cycle after.
REQ-026 The bench SHALL cover an ignored order: in WAIT_TX, sof_rx alone -> no change; a later sof_tx then sof_rx -> normal completion.
REQ-027 The bench SHALL cover reset mid-change: rst in WAIT_RX after the TX load -> tx returns to (1,1,0), no rx_applied pulse, INIT restarts.
